// File: rtl/sm_reg_dump_pkg.sv
// sm_reg_dump_pkg: FSM state encoding and ASCII constants shared by the register dump block
package sm_reg_dump_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HEX,
    ST_SEP,
    ST_LF,
    ST_DONE
  } state_t;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
endpackage

// File: rtl/sm_hex_ascii.sv
// sm_hex_ascii: combinational nibble (in 4) to uppercase ASCII hex digit (out 8)
module sm_hex_ascii
  import sm_reg_dump_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);
  assign ascii = nibble < 4'd10 ? ASCII_0 + {4'd0, nibble} : ASCII_A + {4'd0, nibble} - 8'd10;
endmodule

// File: rtl/sm_reg_dump.sv
// sm_reg_dump: sweeps the core debug port (regAddr out / regData in) and streams each register as ASCII hex over txData/txValid/txReady; start in, busy/done out, rst_n sync active-low
module sm_reg_dump
  import sm_reg_dump_pkg::*;
#(
  parameter int REG_FIRST = 0,
  parameter int REG_LAST  = 31,
  parameter int SETTLE    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [4:0] FIRST = 5'(REG_FIRST);
  localparam logic [4:0] LAST = 5'(REG_LAST);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);
  state_t st;
  logic [CW-1:0] cnt;
  logic [31:0] snap;
  logic [2:0] idx;
  logic [3:0] nib;
  logic [7:0] asc;
  assign nib = st == ST_CAPTURE ? regData[31:28] : snap[{idx - 3'd1, 2'b00} +: 4];
  sm_hex_ascii u_hex (
    .nibble(nib),
    .ascii (asc)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= ST_IDLE;
      regAddr <= '0;
      txValid <= 1'b0;
      txData  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      snap    <= '0;
      idx     <= '0;
    end else begin
      case (st)
        ST_IDLE: if (start) begin
          regAddr <= FIRST;
          cnt     <= SETTLE_LOAD;
          busy    <= 1'b1;
          st      <= ST_SETTLE;
        end
        ST_SETTLE: if (cnt == '0) st <= ST_CAPTURE;
        else cnt <= cnt - 1'b1;
        ST_CAPTURE: begin
          snap    <= regData;
          idx     <= 3'd7;
          txData  <= asc;
          txValid <= 1'b1;
          st      <= ST_HEX;
        end
        ST_HEX: if (txReady) begin
          if (idx == 3'd0) begin
            txData <= regAddr == LAST ? ASCII_CR : ASCII_SP;
            st     <= ST_SEP;
          end else begin
            idx    <= idx - 3'd1;
            txData <= asc;
          end
        end
        ST_SEP: if (txReady) begin
          if (regAddr == LAST) begin
            txData <= ASCII_LF;
            st     <= ST_LF;
          end else begin
            regAddr <= regAddr + 5'd1;
            cnt     <= SETTLE_LOAD;
            txValid <= 1'b0;
            txData  <= '0;
            st      <= ST_SETTLE;
          end
        end
        ST_LF: if (txReady) begin
          txValid <= 1'b0;
          txData  <= '0;
          done    <= 1'b1;
          st      <= ST_DONE;
        end
        ST_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          st   <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sm_reg_dump.sv
// tb_sm_reg_dump: table, directed and randomized checks of sm_reg_dump against a byte-stream model
module tb_sm_reg_dump;
  localparam int SF = 0, SL = 1, SS = 2;
  localparam int FF = 0, FL = 31, FS = 1;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn_s = 1'b0, start_s = 1'b0, rdy_s = 1'b0, busy_s, done_s, txv_s;
  logic [4:0] addr_s;
  logic [31:0] data_s;
  logic [7:0] txd_s;
  logic rstn_f = 1'b0, start_f = 1'b0, rdy_f = 1'b0, busy_f, done_f, txv_f;
  logic [4:0] addr_f;
  logic [31:0] data_f;
  logic [7:0] txd_f;
  logic [31:0] regs_s [32];
  logic [31:0] regs_f [32];
  logic [31:0] noise = '0;
  logic scramble = 1'b0;
  assign data_s = regs_s[addr_s];
  assign data_f = (scramble && txv_f && addr_f == 5'd5) ? noise : regs_f[addr_f];
  sm_reg_dump #(.REG_FIRST(SF), .REG_LAST(SL), .SETTLE(SS)) u_s (
    .clk(clk), .rst_n(rstn_s), .start(start_s), .busy(busy_s), .done(done_s),
    .regAddr(addr_s), .regData(data_s), .txData(txd_s), .txValid(txv_s), .txReady(rdy_s)
  );
  sm_reg_dump #(.REG_FIRST(FF), .REG_LAST(FL), .SETTLE(FS)) u_f (
    .clk(clk), .rst_n(rstn_f), .start(start_f), .busy(busy_f), .done(done_f),
    .regAddr(addr_f), .regData(data_f), .txData(txd_f), .txValid(txv_f), .txReady(rdy_f)
  );
  typedef struct {
    logic [31:0] r0;
    logic [31:0] r1;
    logic [151:0] txt;
  } vec_t;
  vec_t vecs [4];
  int n_cmp = 0, n_bad = 0;
  logic cv, cb, cdn;
  logic [7:0] cd;
  logic [4:0] ca;
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  logic stall_p = 1'b0;
  logic [7:0] pd = '0;
  int busyc, addr_chg;
  logic addr_seen;
  logic [4:0] last_a;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask
  task automatic sample(input int d);
    @(negedge clk);
    noise = $urandom;
    if (d == 0) begin
      cv = txv_s; cd = txd_s; cb = busy_s; cdn = done_s; ca = addr_s;
    end else begin
      cv = txv_f; cd = txd_f; cb = busy_f; cdn = done_f; ca = addr_f;
    end
  endtask
  task automatic drive(input int d, input logic st, input logic rd, input logic rn);
    int fi;
    fi = d == 0 ? SF : FF;
    if (d == 0) begin
      start_s = st; rdy_s = rd; rstn_s = rn;
    end else begin
      start_f = st; rdy_f = rd; rstn_f = rn;
    end
    if (stall_p) begin
      check("stall_valid", {31'd0, cv}, 32'd1);
      check("stall_data", {24'd0, cd}, {24'd0, pd});
    end
    stall_p = rn && cv && !rd;
    pd = cd;
    if (rn && cv && rd) got_q.push_back(cd);
    if (cb) begin
      busyc++;
      if (!addr_seen) begin
        check("addr_first", {27'd0, ca}, fi);
        addr_seen = 1'b1;
        last_a = ca;
      end else if (ca != last_a) begin
        check("addr_step", {27'd0, ca}, int'(last_a) + 1);
        addr_chg++;
        last_a = ca;
      end
    end
  endtask
  task automatic build(input int d);
    int fi, li, n;
    logic [31:0] v;
    fi = d == 0 ? SF : FF;
    li = d == 0 ? SL : FL;
    exp_q.delete();
    for (int r = fi; r <= li; r++) begin
      v = d == 0 ? regs_s[r] : regs_f[r];
      for (int i = 7; i >= 0; i--) begin
        n = int'((v >> (4 * i)) & 32'hF);
        exp_q.push_back(n < 10 ? 8'(48 + n) : 8'(65 + n - 10));
      end
      exp_q.push_back(r == li ? 8'h0D : 8'h20);
    end
    exp_q.push_back(8'h0A);
  endtask
  task automatic run_dump(input int d, input bit rand_rdy, input bit spam, input int exp_busy, input string tag);
    int li, fi;
    bit fin;
    fi = d == 0 ? SF : FF;
    li = d == 0 ? SL : FL;
    got_q.delete();
    busyc = 0; addr_chg = 0; addr_seen = 1'b0; stall_p = 1'b0;
    sample(d);
    check({tag, "_idle_busy"}, {31'd0, cb}, 32'd0);
    check({tag, "_idle_done"}, {31'd0, cdn}, 32'd0);
    drive(d, 1'b1, 1'b1, 1'b1);
    fin = 1'b0;
    for (int k = 0; k < 6000 && !fin; k++) begin
      sample(d);
      drive(d, spam && cb, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b1);
      if (cdn) fin = 1'b1;
    end
    check({tag, "_timeout"}, {31'd0, fin}, 32'd1);
    check({tag, "_done_busy"}, {31'd0, cb}, 32'd1);
    check({tag, "_done_valid"}, {31'd0, cv}, 32'd0);
    check({tag, "_addr_hold"}, {27'd0, ca}, li);
    check({tag, "_addr_sweep"}, addr_chg, li - fi);
    if (exp_busy >= 0) check({tag, "_busy_cycles"}, busyc, exp_busy);
    build(d);
    check({tag, "_byte_count"}, got_q.size(), exp_q.size());
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++)
      check({tag, "_byte"}, {24'd0, got_q[j]}, {24'd0, exp_q[j]});
  endtask
  initial begin
    bit fin;
    int n0;
    vecs[0] = '{32'h00000010, 32'h000000AB, "00000010 000000AB\015\012"};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, "FFFFFFFF 00000000\015\012"};
    vecs[2] = '{32'h01234567, 32'h89ABCDEF, "01234567 89ABCDEF\015\012"};
    vecs[3] = '{32'h9A0F5C3E, 32'hA5A5A5A5, "9A0F5C3E A5A5A5A5\015\012"};
    for (int i = 0; i < 32; i++) begin
      regs_s[i] = $urandom;
      regs_f[i] = 32'(i) * 32'h11111111;
    end
    repeat (2) @(negedge clk);
    check("rst_busy_s", {31'd0, busy_s}, 32'd0);
    check("rst_done_s", {31'd0, done_s}, 32'd0);
    check("rst_valid_s", {31'd0, txv_s}, 32'd0);
    check("rst_data_s", {24'd0, txd_s}, 32'd0);
    check("rst_addr_s", {27'd0, addr_s}, 32'd0);
    check("rst_valid_f", {31'd0, txv_f}, 32'd0);
    check("rst_addr_f", {27'd0, addr_f}, 32'd0);
    rstn_s = 1'b1;
    rstn_f = 1'b1;
    for (int i = 0; i < 8; i++) begin
      regs_s[0] = vecs[i % 4].r0;
      regs_s[1] = vecs[i % 4].r1;
      run_dump(0, i >= 4, 1'b0, i >= 4 ? -1 : 2 * (SS + 10) + 2, "vec");
      check("vec_len", got_q.size(), 19);
      for (int j = 0; j < 19 && j < got_q.size(); j++)
        check("vec_byte", {24'd0, got_q[j]}, {24'd0, vecs[i % 4].txt[8 * (18 - j) +: 8]});
    end
    run_dump(1, 1'b0, 1'b0, 32 * (FS + 10) + 2, "full");
    run_dump(1, 1'b0, 1'b1, 32 * (FS + 10) + 2, "spam");
    run_dump(1, 1'b1, 1'b0, -1, "second");
    regs_f[5] = 32'hDEADBEEF;
    scramble = 1'b1;
    run_dump(1, 1'b1, 1'b0, -1, "scramble");
    scramble = 1'b0;
    regs_s[0] = 32'h13579BDF;
    regs_s[1] = 32'h2468ACE0;
    got_q.delete();
    busyc = 0; addr_chg = 0; addr_seen = 1'b0; stall_p = 1'b0;
    sample(0);
    drive(0, 1'b1, 1'b1, 1'b1);
    fin = 1'b0;
    for (int k = 0; k < 200 && !fin; k++) begin
      sample(0);
      if (got_q.size() == 12) begin
        check("rst_mid_in_hex", {31'd0, cv}, 32'd1);
        drive(0, 1'b0, 1'b1, 1'b0);
        fin = 1'b1;
      end else drive(0, 1'b0, 1'b1, 1'b1);
    end
    check("rst_mid_reached", {31'd0, fin}, 32'd1);
    sample(0);
    check("rst_mid_valid", {31'd0, cv}, 32'd0);
    check("rst_mid_busy", {31'd0, cb}, 32'd0);
    check("rst_mid_addr", {27'd0, ca}, 32'd0);
    check("rst_mid_data", {24'd0, cd}, 32'd0);
    check("rst_mid_done", {31'd0, cdn}, 32'd0);
    drive(0, 1'b0, 1'b1, 1'b1);
    n0 = got_q.size();
    repeat (20) begin
      sample(0);
      drive(0, 1'b0, 1'b1, 1'b1);
    end
    check("rst_quiet_bytes", got_q.size(), n0);
    check("rst_quiet_busy", {31'd0, cb}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      regs_s[0] = $urandom;
      regs_s[1] = $urandom;
      run_dump(0, 1'($urandom_range(0, 1)), 1'b0, -1, "rand_s");
    end
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 32; r++) regs_f[r] = $urandom;
      run_dump(1, 1'b1, 1'b0, -1, "rand_f");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sm_reg_dump.md
Name: sm_reg_dump

Overview:
Debug-port initiator for the schoolMIPS core. It drives the core's regAddr/regData debug read port and sweeps a register range on request. Each register value is snapshotted and serialised as uppercase ASCII hex bytes over a valid/ready byte stream, which normally feeds a UART transmitter. The block sits beside sm_cpu in the board top level.

Parameters:
REG_FIRST, 0, first register index dumped; index 0 returns the PC on the core's debug port.
REG_LAST, 31, last register index dumped; REG_FIRST <= REG_LAST <= 31 is required.
SETTLE, 1, clock cycles (>= 1) to hold regAddr before regData is sampled.

Ports:
clk  in  1  system clock; one clock domain, all logic on the rising edge
rst_n  in  1  reset, synchronous, active-low
start  in  1  dump request; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until DONE is left
done  out  1  one-cycle pulse when the final byte has been accepted
regAddr  out  5  debug register address driven to the core
regData  in  32  debug register data from the core; combinational on regAddr
txData  out  8  ASCII byte
txValid  out  1  byte valid
txReady  in  1  sink accepts the byte when txValid and txReady are both high

Behaviour:
- Reset (rst_n low at a rising edge) forces state IDLE, regAddr=0, txValid=0, txData=0, busy=0, done=0, and clears the counters and snapshot. Reset mid-dump aborts the dump with no further bytes; txValid is low from the first edge after reset is applied.
- States: IDLE, SETTLE, CAPTURE, HEX, SEP, LF, DONE.
- IDLE: on start=1, load regAddr=REG_FIRST and the settle counter, then go to SETTLE. start in any other state is ignored, including DONE.
- SETTLE: hold regAddr for SETTLE cycles, then go to CAPTURE.
- CAPTURE (1 cycle): snapshot<=regData, nibble index<=7, then go to HEX. Later changes on regData do not affect the bytes sent.
- HEX: txValid=1, txData=ASCII of snapshot nibble [index]. Nibble 0-9 maps to 0x30-0x39; A-F maps to 0x41-0x46. On handshake, decrement the index; after the handshake at index 0, go to SEP.
- SEP: txValid=1. txData=0x20 (space) if regAddr!=REG_LAST, else 0x0D (CR). On handshake:
  - not last: regAddr+1, go to SETTLE;
  - last: go to LF.
- LF: txValid=1, txData=0x0A. On handshake, go to DONE.
- DONE (1 cycle): done=1, busy=1, then go to IDLE.
- Handshake rule: while txValid=1 and txReady=0, txData and txValid hold stable. txValid never drops without a handshake except on reset. txReady while txValid=0 has no effect.
- Byte count per dump: 9*(REG_LAST-REG_FIRST+1)+1.
- Cycle count with txReady held high: each register costs SETTLE+1+8+1 cycles, plus 1 for LF and 1 for DONE.
- Example: full 0..31 sweep with SETTLE=1 takes 354 cycles from the start-sampling edge to done.
- regAddr only changes in IDLE on start, and in SEP on the handshake. It never exceeds REG_LAST and holds its last value after the dump.

Decomposition:
- Shared header (alongside sm_cpu.vh): state encodings and the ASCII constants for space, CR, LF, '0' and 'A'.
- One natural sub-module: sm_hex_ascii, a combinational 4-bit nibble to 8-bit ASCII converter, instantiated once.

Test Plan:
1. REG_FIRST=0, REG_LAST=1, pc=0x00000010, r1=0x000000AB, txReady=1, start pulse -> bytes "00000010 000000AB" CR LF (0x30 x6,0x31,0x30,0x20,0x30 x6,0x41,0x42,0x0D,0x0A); done high exactly once.
2. Same setup with txReady toggled pseudo-randomly -> identical byte sequence; txData is unchanged across every stalled cycle; no byte is dropped or duplicated.
3. Default parameters, rN=N*0x11111111 truncated to 32 bits, txReady=1 -> regAddr sweeps 0..31 once; 289 bytes; done 354 cycles after the start edge.
4. start pulsed repeatedly while busy and during DONE -> ignored; exactly one dump. A start in the following IDLE cycle begins a second dump.
5. rst_n low for one cycle while in HEX mid-register -> next cycle txValid=0, busy=0, regAddr=0; no bytes until the next start.
6. regData changed every cycle during HEX of r5 (captured 0xDEADBEEF) -> bytes "DEADBEEF" are transmitted regardless of later regData values.
